trigger_ctrl: RTL and testbench

// Parametrised multi-channel level trigger between the ADC capture path and the acquisition buffer.

---
 rtl/trigger_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_trigger_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: multi-channel two's-complement level trigger with hysteresis, arm/holdoff FSM
// and a 3-cycle data delay aligned to the trigger pulse. Define TRIG_TIMESTAMP_EN to add trig_ts.
module trigger_ctrl #(
    parameter int DW     = 14,
    parameter int SEL_W  = 1,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     adc_clk,
    input  logic                     adc_rst,
    input  logic [(2**SEL_W)*DW-1:0] adc_dat,
    output logic [(2**SEL_W)*DW-1:0] adc_dat_out,
    input  logic [SEL_W-1:0]         cfg_sel,
    input  logic [DW-1:0]            cfg_level,
    input  logic [DW-1:0]            cfg_hyst,
    input  logic                     cfg_edge,
    input  logic                     cfg_single,
    input  logic [HOLD_W-1:0]        cfg_holdoff,
    input  logic                     arm,
    input  logic                     disarm,
    output logic                     armed,
    output logic                     trigger,
    output logic [CNT_W-1:0]         trig_cnt
`ifdef TRIG_TIMESTAMP_EN
    ,
    output logic [31:0]              trig_ts
`endif
);

    localparam int N_CH = 2**SEL_W;
    localparam int PW   = N_CH*DW;
    localparam int EW   = DW+2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Sign-extend a sample or level into the widened compare domain.
    function automatic logic signed [EW-1:0] sext(input logic [DW-1:0] v);
        sext = {{2{v[DW-1]}}, v};
    endfunction

    // Zero-extend the unsigned hysteresis band into the compare domain.
    function automatic logic signed [EW-1:0] zext(input logic [DW-1:0] v);
        zext = {2'b00, v};
    endfunction

    logic [DW-1:0]        ch_s [N_CH];
    logic [DW-1:0]        sel_sample_s;
    logic [DW-1:0]        sample_r;
    logic [DW-1:0]        level_r;
    logic [DW-1:0]        hyst_r;
    logic                 edge_r;
    logic                 edge_d_r;
    logic                 act_r;
    logic                 act_d_r;
    logic                 act_next_s;
    logic signed [EW-1:0] s_ext_s;
    logic signed [EW-1:0] lvl_ext_s;
    logic signed [EW-1:0] lo_s;
    logic signed [EW-1:0] hi_s;
    logic                 fire_s;
    state_t               state_r;
    state_t               state_s;
    logic                 hold_load_s;
    logic [HOLD_W-1:0]    hold_cnt_r;
    logic                 armed_r;
    logic                 trigger_r;
    logic [CNT_W-1:0]     trig_cnt_r;
    logic [PW-1:0]        dly0_r;
    logic [PW-1:0]        dly1_r;
    logic [PW-1:0]        dly2_r;

    // Split the packed input bus into channels and pick the configured source.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_s[k] = adc_dat[k*DW +: DW];
        end
        sel_sample_s = ch_s[cfg_sel];
    end

    // Stage 1: register the selected sample together with the compare configuration.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            sample_r <= {DW{1'b0}};
            level_r  <= {DW{1'b0}};
            hyst_r   <= {DW{1'b0}};
            edge_r   <= 1'b0;
        end else begin
            sample_r <= sel_sample_s;
            level_r  <= cfg_level;
            hyst_r   <= cfg_hyst;
            edge_r   <= cfg_edge;
        end
    end

    // Stage 2 compare: widened arithmetic keeps level +/- hyst from wrapping.
    always_comb begin
        s_ext_s    = sext(sample_r);
        lvl_ext_s  = sext(level_r);
        lo_s       = lvl_ext_s - zext(hyst_r);
        hi_s       = lvl_ext_s + zext(hyst_r);
        act_next_s = act_r;
        if (edge_r != edge_d_r) begin
            act_next_s = 1'b0;
        end else if (!edge_r) begin
            if (s_ext_s >= lvl_ext_s) begin
                act_next_s = 1'b1;
            end else if (s_ext_s < lo_s) begin
                act_next_s = 1'b0;
            end else begin
                act_next_s = act_r;
            end
        end else begin
            if (s_ext_s <= lvl_ext_s) begin
                act_next_s = 1'b1;
            end else if (s_ext_s > hi_s) begin
                act_next_s = 1'b0;
            end else begin
                act_next_s = act_r;
            end
        end
    end

    // Stage 2 state: hysteresis flag, its previous value and the previous edge mode.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            act_r    <= 1'b0;
            act_d_r  <= 1'b0;
            edge_d_r <= 1'b0;
        end else begin
            act_r    <= act_next_s;
            act_d_r  <= act_r;
            edge_d_r <= edge_r;
        end
    end

    // Stage 3 qualification and FSM next state; disarm wins over arm and over re-arming.
    always_comb begin
        fire_s      = (state_r == ST_ARMED) && act_r && !act_d_r;
        state_s     = state_r;
        hold_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (disarm) begin
                    state_s = ST_IDLE;
                end else if (arm) begin
                    state_s = ST_ARMED;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    state_s = ST_IDLE;
                end else if (!fire_s) begin
                    state_s = ST_ARMED;
                end else if (cfg_holdoff != {HOLD_W{1'b0}}) begin
                    state_s     = ST_HOLD;
                    hold_load_s = 1'b1;
                end else if (cfg_single) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_HOLD: begin
                if (disarm) begin
                    state_s = ST_IDLE;
                end else if (hold_cnt_r <= {{(HOLD_W-1){1'b0}}, 1'b1}) begin
                    state_s = cfg_single ? ST_IDLE : ST_ARMED;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, holdoff counter and registered control outputs.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {HOLD_W{1'b0}};
            armed_r    <= 1'b0;
            trigger_r  <= 1'b0;
            trig_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            armed_r   <= (state_s == ST_ARMED);
            trigger_r <= fire_s;
            if (hold_load_s) begin
                hold_cnt_r <= cfg_holdoff;
            end else if (state_r == ST_HOLD) begin
                hold_cnt_r <= hold_cnt_r - {{(HOLD_W-1){1'b0}}, 1'b1};
            end
            if (fire_s) begin
                trig_cnt_r <= trig_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Three-deep data delay so adc_dat_out shows the sample that caused the trigger.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            dly0_r <= {PW{1'b0}};
            dly1_r <= {PW{1'b0}};
            dly2_r <= {PW{1'b0}};
        end else begin
            dly0_r <= adc_dat;
            dly1_r <= dly0_r;
            dly2_r <= dly1_r;
        end
    end

    assign adc_dat_out = dly2_r;
    assign armed       = armed_r;
    assign trigger     = trigger_r;
    assign trig_cnt    = trig_cnt_r;

`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] ts_cnt_r;
    logic [31:0] trig_ts_r;

    // Free-running cycle counter; trig_ts takes the count of the cycle the pulse is visible in.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            ts_cnt_r  <= 32'd0;
            trig_ts_r <= 32'd0;
        end else begin
            ts_cnt_r <= ts_cnt_r + 32'd1;
            if (fire_s) begin
                trig_ts_r <= ts_cnt_r + 32'd1;
            end
        end
    end

    assign trig_ts = trig_ts_r;
`endif

endmodule

// File: tb/tb_trigger_ctrl.sv
// Scoreboard bench for trigger_ctrl: a cycle-indexed reference model pushes expected outputs,
// a negedge monitor pops and compares; directed scenarios add spec-level count/spacing checks.
module tb_trigger_ctrl;

    localparam int NCY    = 5000;
    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_HOLD = 2;

    logic        adc_clk = 1'b0;
    logic        adc_rst;
    logic [27:0] adc_dat;
    logic [27:0] adc_dat_out;
    logic [0:0]  cfg_sel;
    logic [13:0] cfg_level;
    logic [13:0] cfg_hyst;
    logic        cfg_edge;
    logic        cfg_single;
    logic [15:0] cfg_holdoff;
    logic        arm;
    logic        disarm;
    logic        armed;
    logic        trigger;
    logic [15:0] trig_cnt;
`ifdef TRIG_TIMESTAMP_EN
    logic [31:0] trig_ts;
`endif

    int ch0, ch1, lvl, hys, hold;
    bit sel, edg, sgl, arm_i, dis_i, rst_i;

    assign adc_rst     = rst_i;
    assign adc_dat     = {ch1[13:0], ch0[13:0]};
    assign cfg_sel     = sel;
    assign cfg_level   = lvl[13:0];
    assign cfg_hyst    = hys[13:0];
    assign cfg_edge    = edg;
    assign cfg_single  = sgl;
    assign cfg_holdoff = hold[15:0];
    assign arm         = arm_i;
    assign disarm      = dis_i;

    always #5 adc_clk = ~adc_clk;

    trigger_ctrl dut (
        .adc_clk     (adc_clk),
        .adc_rst     (adc_rst),
        .adc_dat     (adc_dat),
        .adc_dat_out (adc_dat_out),
        .cfg_sel     (cfg_sel),
        .cfg_level   (cfg_level),
        .cfg_hyst    (cfg_hyst),
        .cfg_edge    (cfg_edge),
        .cfg_single  (cfg_single),
        .cfg_holdoff (cfg_holdoff),
        .arm         (arm),
        .disarm      (disarm),
        .armed       (armed),
        .trigger     (trigger),
        .trig_cnt    (trig_cnt)
`ifdef TRIG_TIMESTAMP_EN
        ,
        .trig_ts     (trig_ts)
`endif
    );

    typedef struct {
        int          cyc;
        bit          trg;
        logic [15:0] cnt;
        bit          arm;
        logic [27:0] dat;
    } exp_t;

    exp_t exp_q[$];
    int   trig_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Recorded inputs per cycle
    int          samp_a[NCY], lvl_a[NCY], hys_a[NCY], hold_a[NCY];
    bit          edg_a[NCY], sgl_a[NCY], arm_a[NCY], dis_a[NCY], rst_a[NCY];
    logic [27:0] dat_a[NCY];
    // Model view per cycle
    int          s1s[NCY], s1l[NCY], s1h[NCY], md[NCY], rel[NCY], cntm[NCY];
    bit          s1e[NCY], ed[NCY], act[NCY], trg[NCY];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Expected outputs for cycle k, derived from the recorded history up to k-1.
    task automatic model(int k);
        exp_t e;
        bit   a, f, rs;
        int   s, l, h, m, nm;
        if (k == 0) return;
        if (rst_a[k-1]) begin
            s1s[k] = 0; s1l[k] = 0; s1h[k] = 0; s1e[k] = 0; ed[k] = 0;
            act[k] = 0; md[k] = M_IDLE; rel[k] = 0; cntm[k] = 0; trg[k] = 0;
        end else begin
            s1s[k] = samp_a[k-1]; s1l[k] = lvl_a[k-1]; s1h[k] = hys_a[k-1];
            s1e[k] = edg_a[k-1];  ed[k]  = s1e[k-1];
            s = s1s[k-1]; l = s1l[k-1]; h = s1h[k-1];
            a = act[k-1];
            if (s1e[k-1] != ed[k-1]) a = 0;
            else if (!s1e[k-1]) begin
                if (s >= l) a = 1;
                else if (s < l - h) a = 0;
            end else begin
                if (s <= l) a = 1;
                else if (s > l + h) a = 0;
            end
            act[k] = a;
            f = (md[k-1] == M_ARM) && act[k-1] && !((k >= 2) && act[k-2]);
            m = md[k-1];
            nm = m;
            rel[k] = rel[k-1];
            if (dis_a[k-1]) nm = M_IDLE;
            else if (m == M_IDLE) nm = arm_a[k-1] ? M_ARM : M_IDLE;
            else if (m == M_ARM) begin
                if (f && hold_a[k-1] != 0) begin
                    nm = M_HOLD;
                    rel[k] = k + hold_a[k-1];
                end else if (f && sgl_a[k-1]) nm = M_IDLE;
            end else if (k >= rel[k-1]) nm = sgl_a[k-1] ? M_IDLE : M_ARM;
            md[k]   = nm;
            trg[k]  = f;
            cntm[k] = (cntm[k-1] + int'(f)) % 65536;
        end
        rs = 0;
        for (int j = k - 3; j < k; j++) if (j < 0 || rst_a[j]) rs = 1;
        e.cyc = k;
        e.trg = trg[k];
        e.cnt = cntm[k][15:0];
        e.arm = (md[k] == M_ARM);
        e.dat = rs ? 28'd0 : dat_a[k-3];
        exp_q.push_back(e);
    endtask

    task automatic step();
        if (cyc >= NCY - 1) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, NCY - 1);
            $fatal(1, "cycle budget exhausted");
        end
        model(cyc);
        samp_a[cyc] = sel ? ch1 : ch0;
        lvl_a[cyc]  = lvl;  hys_a[cyc] = hys;  hold_a[cyc] = hold;
        edg_a[cyc]  = edg;  sgl_a[cyc] = sgl;  arm_a[cyc]  = arm_i;
        dis_a[cyc]  = dis_i; rst_a[cyc] = rst_i;
        dat_a[cyc]  = {ch1[13:0], ch0[13:0]};
        @(posedge adc_clk);
        #1;
        cyc++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every cycle's outputs are compared against the queued expectation.
    always @(negedge adc_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("trigger", {31'd0, trigger}, {31'd0, e.trg});
            check("trig_cnt", {16'd0, trig_cnt}, {16'd0, e.cnt});
            check("armed", {31'd0, armed}, {31'd0, e.arm});
            check("adc_dat_out", {4'd0, adc_dat_out}, {4'd0, e.dat});
            if (trigger === 1'b1) trig_log.push_back(e.cyc);
        end
    end

    initial begin
        #(NCY * 10 + 1000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nseg, first;
        ch0 = 0; ch1 = 0; lvl = 0; hys = 0; hold = 0;
        sel = 0; edg = 0; sgl = 0; arm_i = 0; dis_i = 0; rst_i = 1;
        run(2);
        rst_i = 0;
        check("reset_armed", {31'd0, armed}, 32'd0);
        check("reset_trigger", {31'd0, trigger}, 32'd0);
        check("reset_cnt", {16'd0, trig_cnt}, 32'd0);
        check("reset_dat", {4'd0, adc_dat_out}, 32'd0);

        // Rising ramp through level 100
        lvl = 100; hys = 20; ch0 = 0;
        run(6);
        arm_i = 1; step(); arm_i = 0;
        run(4);
        trig_log.delete();
        t0 = cyc;
        for (int v = 0; v <= 200; v++) begin ch0 = v; step(); end
        run(4);
        first = (trig_log.size() > 0) ? trig_log[0] : -1;
        check("ramp_count", trig_log.size(), 32'd1);
        check("ramp_latency", first, t0 + 103);
        check("ramp_cnt", {16'd0, trig_cnt}, 32'd1);

        // Noise around the level stays inside the band
        ch0 = 0; run(5);
        trig_log.delete();
        for (int i = 0; i < 20; i++) begin ch0 = (i % 2) ? 105 : 95; step(); end
        run(4);
        check("noise_one", trig_log.size(), 32'd1);
        ch0 = 79; run(3);
        ch0 = 100; run(6);
        check("noise_rearm", trig_log.size(), 32'd2);
        check("noise_cnt", {16'd0, trig_cnt}, 32'd3);

        // Falling on channel 1, channel 0 random
        edg = 1; lvl = -500; sel = 1; ch1 = 0;
        run(8);
        trig_log.delete();
        for (int i = 0; i < 30; i++) begin
            ch0 = int'($urandom_range(0, 16383)) - 8192;
            ch1 = (i < 10) ? 0 : -600;
            step();
        end
        run(4);
        check("falling_count", trig_log.size(), 32'd1);

        // Holdoff spacing with a period-4 square wave
        edg = 0; sel = 0; lvl = 100; hys = 20; hold = 10; ch0 = 0;
        run(8);
        trig_log.delete();
        for (int i = 0; i < 64; i++) begin ch0 = (i % 4 < 2) ? 0 : 200; step(); end
        run(4);
        check("holdoff_min3", {31'd0, trig_log.size() >= 3}, 32'd1);
        for (int i = 1; i < trig_log.size(); i++)
            check("holdoff_gap", trig_log[i] - trig_log[i-1], 32'd12);
        hold = 0; ch0 = 0; run(15);

        // Single shot, then simultaneous arm/disarm
        dis_i = 1; step(); dis_i = 0;
        sgl = 1; run(5);
        arm_i = 1; step(); arm_i = 0;
        run(3);
        trig_log.delete();
        for (int i = 0; i < 16; i++) begin ch0 = (i % 8 < 4) ? 0 : 200; step(); end
        run(4);
        check("single_count", trig_log.size(), 32'd1);
        check("single_disarmed", {31'd0, armed}, 32'd0);
        ch0 = 0;
        arm_i = 1; dis_i = 1; step(); arm_i = 0; dis_i = 0;
        run(3);
        check("arm_disarm_idle", {31'd0, armed}, 32'd0);

        // Reset while in holdoff
        sgl = 0; hold = 50; ch0 = 0;
        arm_i = 1; step(); arm_i = 0;
        run(4);
        trig_log.delete();
        ch0 = 200; run(6);
        check("hold_fire", trig_log.size(), 32'd1);
        rst_i = 1; step(); rst_i = 0;
        check("rst_hold_armed", {31'd0, armed}, 32'd0);
        check("rst_hold_cnt", {16'd0, trig_cnt}, 32'd0);
        check("rst_hold_dat", {4'd0, adc_dat_out}, 32'd0);
`ifdef TRIG_TIMESTAMP_EN
        check("rst_hold_ts", trig_ts, 32'd0);
`endif
        trig_log.delete();
        run(20);
        check("rst_no_trigger", trig_log.size(), 32'd0);

        // Randomized segments against the model
        for (int seg = 0; seg < 24; seg++) begin
            sel  = 1'($urandom_range(0, 1));
            edg  = 1'($urandom_range(0, 1));
            sgl  = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
            lvl  = int'($urandom_range(0, 400)) - 200;
            hys  = int'($urandom_range(0, 100));
            if (seg % 8 == 7) begin
                lvl = edg ? 8191 : -8192;
                hys = 16383;
            end
            nseg = int'($urandom_range(40, 110));
            for (int i = 0; i < nseg; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    ch0 = int'($urandom_range(0, 16383)) - 8192;
                    ch1 = int'($urandom_range(0, 16383)) - 8192;
                end else begin
                    ch0 = int'($urandom_range(0, 700)) - 350;
                    ch1 = int'($urandom_range(0, 700)) - 350;
                end
                arm_i = ($urandom_range(0, 9) == 0);
                dis_i = ($urandom_range(0, 49) == 0);
                rst_i = ($urandom_range(0, 299) == 0);
                step();
            end
            arm_i = 0; dis_i = 0; rst_i = 0;
        end
        run(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
